// File: rtl/rv32_mod_instr_prefetch.sv
// rv32_mod_instr_prefetch
//   Sequential instruction prefetch buffer. Fetches aligned words ahead of
//   the core into a DEPTH-entry FIFO and answers in-order core fetches from
//   the FIFO head in the same cycle. A core address that does not match the
//   head flushes the buffer and restarts prefetching from that address.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   core_req/core_addr    core fetch request (held until core_ack)
//   core_ack/core_err/    completion (combinational), error flag and word
//   core_data
//   mem_req/mem_addr      memory request, registered, held until mem_ack
//   mem_ack/mem_err/      memory completion, error flag and read data
//   mem_data
module rv32_mod_instr_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  output logic        core_ack,
  output logic        core_err,
  output logic [31:0] core_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD, HALT} state_t;

  state_t            state;
  logic [31:0]       data_q [DEPTH];
  logic [DEPTH-1:0]  err_q;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic [PW:0]       count_next;
  logic [31:0]       head_addr;
  logic [31:0]       fetch_addr;
  logic [31:0]       core_word;
  logic              addr_match;
  logic              hit;
  logic              miss;
  logic              push;
  logic              pop;

  // head_addr is always word aligned, so masking the core address makes the
  // comparison a pure word-address match.
  assign core_word  = core_addr & ~32'd3;
  assign addr_match = (core_word == head_addr);
  assign hit        = core_req && (count != '0) && addr_match;
  // A request that matches the head but finds the FIFO empty is a wait;
  // everything else that does not match the head is a miss.
  assign miss       = core_req && !addr_match;
  assign pop        = hit;
  // Data returned while the core is redirecting belongs to the old stream.
  assign push       = (state == BUSY) && mem_ack && !miss;
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  assign core_ack   = hit;
  assign core_data  = hit ? data_q[rd_ptr] : 32'h0;
  assign core_err   = hit && err_q[rd_ptr];

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= mem_data;
      err_q[wr_ptr]  <= mem_err;
    end
  end

  // FIFO bookkeeping and memory-side FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_addr  <= RESET_PC;
      fetch_addr <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
    end else begin
      if (miss) begin
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        head_addr  <= core_word;
        fetch_addr <= core_word;
      end else begin
        count <= count_next;
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          head_addr <= head_addr + 32'd4;
        end
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          fetch_addr <= fetch_addr + 32'd4;
        end
      end

      case (state)
        IDLE: begin
          // A redirect from IDLE issues the new address immediately so a
          // cold miss sees its memory request in the very next cycle.
          if (miss) begin
            state    <= BUSY;
            mem_req  <= 1'b1;
            mem_addr <= core_word;
          end else if (count < DEPTH_C) begin
            state    <= BUSY;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        BUSY: begin
          if (miss) begin
            // The bus request cannot be withdrawn; wait for its ack and drop it.
            if (mem_ack) begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end else begin
              state   <= DISCARD;
            end
          end else if (mem_ack) begin
            if (mem_err) begin
              state   <= HALT;
              mem_req <= 1'b0;
            end else if (count_next < DEPTH_C) begin
              mem_addr <= fetch_addr + 32'd4;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        HALT: begin
          // Buffered words, including the faulting one, still drain; only a
          // redirect restarts fetching.
          if (miss) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mod_instr_prefetch.sv
// Directed bench for rv32_mod_instr_prefetch with a behavioural memory of
// configurable latency and a scoreboard of expected core responses.
module tb_rv32_mod_instr_prefetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic [31:0] core_addr;
  logic        core_ack;
  logic        core_err;
  logic [31:0] core_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_data;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat_cfg  = 1;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h8;
  int          wcnt;
  logic [31:0] mem_log [$];
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  rv32_mod_instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .core_addr (core_addr),
    .core_ack  (core_ack),
    .core_err  (core_err),
    .core_data (core_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .mem_data  (mem_data)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: acks in the lat_cfg-th cycle of a request.
  always_ff @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end
  assign mem_ack  = mem_req && (wcnt >= lat_cfg - 1);
  assign mem_data = mdata(mem_addr);
  assign mem_err  = mem_ack && err_en && (mem_addr == err_addr);

  always @(negedge clk) begin
    if (mem_req && mem_ack) mem_log.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_req = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    mem_log.delete();
    sb.delete();
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the acked cycle.
  task automatic fetch(input string tag, input logic [31:0] a, input logic e, output int lat);
    logic [32:0] ex;
    core_req  = 1'b1;
    core_addr = a;
    sb.push_back({e, mdata(a)});
    lat = 0;
    #1;
    while (!core_ack && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    ex = sb.pop_front();
    if (!core_ack) begin
      chk({tag, " ack"}, 32'(core_ack), 32'd1);
    end else begin
      chk({tag, " data"}, core_data, ex[31:0]);
      chk({tag, " err"}, 32'(core_err), 32'(ex[32]));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    core_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] exp_seq [5];
    core_req  = 1'b0;
    core_addr = 32'h0;
    reset     = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst core_ack", 32'(core_ack), 32'd0);
    chk("rst core_err", 32'(core_err), 32'd0);
    chk("rst core_data", core_data, 32'h0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    core_req = 1'b1;
    #1;
    chk("rst no hit", 32'(core_ack), 32'd0);
    core_req = 1'b0;

    // Sequential run
    lat_cfg = 1;
    do_reset();
    fetch("seq 0x0", 32'h0, 1'b0, lat);
    for (int i = 1; i < 4; i++) begin
      fetch("seq word", 32'(4 * i), 1'b0, lat);
      chk("seq latency", 32'(lat), 32'd0);
    end
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 5; i++) chk("seq mem_addr", mem_log[i], exp_seq[i]);

    // Full FIFO
    do_reset();
    idle(10);
    chk("full count", 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("full mem_addr", mem_log[i], 32'(4 * i));
    chk("full mem_req", 32'(mem_req), 32'd0);
    fetch("full pop", 32'h0, 1'b0, lat);
    chk("full pop latency", 32'(lat), 32'd0);
    idle(4);
    chk("refill count", 32'(mem_log.size()), 32'd5);
    chk("refill addr", mem_log[4], 32'h10);
    chk("refill mem_req", 32'(mem_req), 32'd0);

    // Flush with in-flight request
    lat_cfg = 3;
    do_reset();
    for (int i = 0; i < 100 && !(mem_req && mem_addr == 32'h8); i++) begin
      @(negedge clk);
      #1;
    end
    chk("flush reach 0x8", mem_addr, 32'h8);
    fetch("flush 0x100", 32'h100, 1'b0, lat);
    chk("flush dropped 0x8", mem_log[2], 32'h8);
    chk("flush next addr", mem_log[3], 32'h100);
    fetch("flush 0x104", 32'h104, 1'b0, lat);
    idle(1);

    // Error halt
    lat_cfg  = 1;
    err_en   = 1'b1;
    err_addr = 32'h8;
    do_reset();
    fetch("err 0x0", 32'h0, 1'b0, lat);
    fetch("err 0x4", 32'h4, 1'b0, lat);
    fetch("err 0x8", 32'h8, 1'b1, lat);
    idle(4);
    chk("halt mem_req", 32'(mem_req), 32'd0);
    chk("halt count", 32'(mem_log.size()), 32'd3);
    fetch("resume 0x200", 32'h200, 1'b0, lat);
    err_en = 1'b0;
    chk("resume addr", mem_log[3], 32'h200);
    fetch("resume 0x204", 32'h204, 1'b0, lat);
    idle(1);

    // Address wrap
    lat_cfg = 1;
    do_reset();
    fetch("wrap F8", 32'hFFFF_FFF8, 1'b0, lat);
    chk("cold miss latency", 32'(lat), 32'd2);
    fetch("wrap FC", 32'hFFFF_FFFC, 1'b0, lat);
    fetch("wrap 00", 32'h0, 1'b0, lat);
    chk("wrap addr0", mem_log[0], 32'hFFFF_FFF8);
    chk("wrap addr1", mem_log[1], 32'hFFFF_FFFC);
    chk("wrap addr2", mem_log[2], 32'h0);
    idle(1);

    // Reset mid-operation
    lat_cfg = 3;
    do_reset();
    for (int i = 0; i < 100 && !(mem_req && mem_addr == 32'h8); i++) begin
      @(negedge clk);
      #1;
    end
    chk("midrst reach 0x8", mem_addr, 32'h8);
    reset = 1'b1;
    @(negedge clk);
    core_req  = 1'b1;
    core_addr = 32'h0;
    #1;
    chk("midrst core_ack", 32'(core_ack), 32'd0);
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst mem_addr", mem_addr, 32'h0);
    core_req = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    #1;
    chk("restart mem_req", 32'(mem_req), 32'd1);
    chk("restart mem_addr", mem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
